// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: FSM state encodings and
// the packed bundle widths used at each inter-stage boundary.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b10;

  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 96;
  localparam int MEM_WB_W = 64;

endpackage

// File: rtl/pipe_reg_en.sv
// Enable-and-load register with synchronous reset to a fixed value.
module pipe_reg_en #(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid bit, OR-reduced stall, flush-to-bubble,
// a one-entry skid buffer keeping in_ready registered, and a stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VAL   = {WIDTH{1'b0}},
  parameter int               NUM_STALL = 2,
  parameter int               CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic [NUM_STALL-1:0] stall_in,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             ready_q, valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, skid_q;
  logic             hold, accept;

  assign hold   = |stall_in;
  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    skid_d  = in_data;
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      main_d  = NOP_VAL;
      skid_en = 1'b1;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        // A bubble may always be overwritten, even while held.
        ST_EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (!hold) begin
            main_en = 1'b1;
            if (!accept) begin
              main_d  = NOP_VAL;
              state_d = ST_EMPTY;
            end
          end else if (accept) begin
            skid_en = 1'b1;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (!hold) begin
            main_en = 1'b1;
            main_d  = skid_q;
            skid_en = 1'b1;
            skid_d  = NOP_VAL;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_en = 1'b1;
          main_d  = NOP_VAL;
          skid_en = 1'b1;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hold && valid_q && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Ready and valid are flopped from next state so neither has a
  // combinational path from stall_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_SKID);
      valid_q <= (state_d != ST_EMPTY);
      cnt_q   <= cnt_d;
    end
  end

  pipe_reg_en #(.WIDTH(WIDTH), .RST_VAL(NOP_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_reg_en #(.WIDTH(WIDTH), .RST_VAL(NOP_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (skid_d),
    .q   (skid_q)
  );

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table plus an in-order
// scoreboard of accepted words, and hand sequences for reset/saturation.
module tb_pipe_stage_skid;

  localparam int               W   = 16;
  localparam logic [W-1:0]     NOP = 16'hBEEF;
  localparam int               NS  = 2;
  localparam int               CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [NS-1:0] stall_in;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] sb_q[$];

  pipe_stage_skid #(.WIDTH(W), .NOP_VAL(NOP), .NUM_STALL(NS), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall_in  (stall_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic [NS-1:0] st;
    logic          f;
    logic          ev;
    logic [W-1:0]  ed;
    logic          er;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle; the scoreboard pops a word when it leaves downstream
  // (valid, not held, not flushed) and pushes each accepted word.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [NS-1:0] st, input logic f);
    logic [W-1:0] exp_w;
    in_valid = v;
    in_data  = d;
    stall_in = st;
    flush    = f;
    #1;
    if (rst || f) begin
      sb_q.delete();
    end else begin
      if (out_valid && (st == '0)) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_underflow: got %0h expected none", out_data);
        end else begin
          exp_w = sb_q.pop_front();
          check("sb_data", {16'h0, out_data}, {16'h0, exp_w});
        end
      end
      if (v && in_ready) sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic [NS-1:0] st, logic f,
                              logic ev, logic [W-1:0] ed, logic er, logic [CW-1:0] ec);
    vec_t r;
    r.v = v; r.d = d; r.st = st; r.f = f;
    r.ev = ev; r.ed = ed; r.er = er; r.ec = ec;
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h00A5; stall_in = '0; flush = 1'b0;

    // Reset held two cycles with live input.
    step(1'b1, 16'h00A5, 2'b00, 1'b0);
    step(1'b1, 16'h00A5, 2'b00, 1'b0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data",  {16'h0, out_data},  {16'h0, NOP});
    check("rst_ready", {31'h0, in_ready},  32'h1);
    check("rst_cnt",   {28'h0, stall_cnt}, 32'h0);
    $display("reset: valid=%0b data=%0h ready=%0b cnt=%0d", out_valid, out_data, in_ready, stall_cnt);
    rst = 1'b0;

    // Stream, skid, bubble squeeze, flush-over-skid.
    vecs[0]  = mk(1, 16'h0001, 2'b00, 0, 1, 16'h0001, 1, 0);
    vecs[1]  = mk(1, 16'h0002, 2'b00, 0, 1, 16'h0002, 1, 0);
    vecs[2]  = mk(1, 16'h0003, 2'b00, 0, 1, 16'h0003, 1, 0);
    vecs[3]  = mk(1, 16'h0004, 2'b00, 0, 1, 16'h0004, 1, 0);
    vecs[4]  = mk(0, 16'h0000, 2'b00, 0, 0, NOP,      1, 0);
    vecs[5]  = mk(1, 16'h0010, 2'b00, 0, 1, 16'h0010, 1, 0);
    vecs[6]  = mk(1, 16'h0011, 2'b01, 0, 1, 16'h0010, 0, 1);
    vecs[7]  = mk(0, 16'h0000, 2'b01, 0, 1, 16'h0010, 0, 2);
    vecs[8]  = mk(0, 16'h0000, 2'b01, 0, 1, 16'h0010, 0, 3);
    vecs[9]  = mk(0, 16'h0000, 2'b00, 0, 1, 16'h0011, 1, 3);
    vecs[10] = mk(0, 16'h0000, 2'b00, 0, 0, NOP,      1, 3);
    vecs[11] = mk(1, 16'h0022, 2'b11, 0, 1, 16'h0022, 1, 3);
    vecs[12] = mk(1, 16'h0033, 2'b01, 0, 1, 16'h0022, 0, 4);
    vecs[13] = mk(1, 16'h0044, 2'b01, 1, 0, NOP,      1, 4);
    vecs[14] = mk(0, 16'h0000, 2'b00, 0, 0, NOP,      1, 4);
    vecs[15] = mk(0, 16'h0000, 2'b01, 0, 0, NOP,      1, 4);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].st, vecs[i].f);
      check("vec_valid", {31'h0, out_valid}, {31'h0, vecs[i].ev});
      check("vec_data",  {16'h0, out_data},  {16'h0, vecs[i].ed});
      check("vec_ready", {31'h0, in_ready},  {31'h0, vecs[i].er});
      check("vec_cnt",   {28'h0, stall_cnt}, {28'h0, vecs[i].ec});
      $display("vec %0d: in v=%0b d=%0h st=%b f=%0b -> valid=%0b data=%0h ready=%0b cnt=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].st, vecs[i].f, out_valid, out_data, in_ready, stall_cnt);
    end
    check("sb_drained", sb_q.size(), 32'h0);

    // Counter saturation: 20 held-valid cycles on a 4-bit counter.
    rst = 1'b1;
    step(1'b0, 16'h0000, 2'b00, 1'b0);
    rst = 1'b0;
    step(1'b1, 16'h0055, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 2'b10, 1'b0);
    check("sat_cnt",   {28'h0, stall_cnt}, 32'hF);
    check("sat_valid", {31'h0, out_valid}, 32'h1);
    check("sat_data",  {16'h0, out_data},  32'h0055);
    $display("saturate: valid=%0b data=%0h cnt=%0d", out_valid, out_data, stall_cnt);

    // Reset mid-hold.
    rst = 1'b1;
    step(1'b1, 16'h0066, 2'b10, 1'b1);
    rst = 1'b0;
    check("rst2_cnt",   {28'h0, stall_cnt}, 32'h0);
    check("rst2_valid", {31'h0, out_valid}, 32'h0);
    check("rst2_data",  {16'h0, out_data},  {16'h0, NOP});
    check("rst2_ready", {31'h0, in_ready},  32'h1);
    $display("reset mid-hold: valid=%0b data=%0h ready=%0b cnt=%0d", out_valid, out_data, in_ready, stall_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
